// File: rtl/polar_to_cart_pkg.sv
// Shared types and constants for the polar_to_cart CORDIC converter.
// Q formats: X/Y accumulators are Q10, the angle accumulator is degrees in Q8.
package polar_to_cart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_DONE
  } state_t;

  localparam int K_INV     = 622;
  localparam int FRAC_XY   = 10;
  localparam int FRAC_Z    = 8;
  localparam int XW        = 20;
  localparam int ZW        = 18;
  localparam int IW        = 4;
  localparam int ATAN_N    = 12;
  localparam int HALF_TURN = 180 << FRAC_Z;

  // round(atan(2^-i) * 256 * 180 / pi)
  localparam logic signed [ZW-1:0] ATAN_TAB [ATAN_N] = '{
    18'sd11520, 18'sd6801, 18'sd3593, 18'sd1824,
    18'sd916,   18'sd458,  18'sd229,  18'sd115,
    18'sd57,    18'sd29,   18'sd14,   18'sd7
  };

endpackage

// File: rtl/polar_to_cart_step.sv
// One combinational CORDIC micro-rotation in rotation mode.
// All three outputs derive from the same (previous) accumulator values.
module polar_to_cart_step
  import polar_to_cart_pkg::*;
(
  input  logic signed [XW-1:0] i_x,
  input  logic signed [XW-1:0] i_y,
  input  logic signed [ZW-1:0] i_z,
  input  logic        [IW-1:0] i_idx,
  input  logic signed [ZW-1:0] i_atan,
  output logic signed [XW-1:0] o_x,
  output logic signed [XW-1:0] o_y,
  output logic signed [ZW-1:0] o_z
);

  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;

  always_comb begin
    w_xs = i_x >>> i_idx;
    w_ys = i_y >>> i_idx;
    if (!i_z[ZW-1]) begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - i_atan;
    end else begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + i_atan;
    end
  end

endmodule

// File: rtl/polar_to_cart.sv
// Iterative CORDIC polar-to-Cartesian converter with ready/valid on both sides.
// Define POLAR_TO_CART_SAT_EN to saturate results to -128..127 instead of wrapping.
module polar_to_cart
  import polar_to_cart_pkg::*;
#(
  parameter int ITER = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic        [7:0] r,
  input  logic signed [8:0] theta,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] x,
  output logic signed [7:0] y,
  output logic              out_err
);

  localparam logic [IW-1:0] LAST = IW'(ITER - 1);

  state_t               r_state;
  state_t               w_state_nx;
  logic                 r_live;
  logic        [IW-1:0] r_cnt;
  logic        [7:0]    r_r;
  logic signed [8:0]    r_theta;
  logic signed [XW-1:0] r_xacc;
  logic signed [XW-1:0] r_yacc;
  logic signed [ZW-1:0] r_zacc;
  logic                 r_err;
  logic signed [7:0]    r_x;
  logic signed [7:0]    r_y;
  logic                 r_oerr;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_bad;
  logic signed [XW-1:0] w_xinit;
  logic signed [ZW-1:0] w_zinit;
  logic signed [XW-1:0] w_xn;
  logic signed [XW-1:0] w_yn;
  logic signed [ZW-1:0] w_zn;

  function automatic logic signed [7:0] fit8(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] w_rnd;
    w_rnd = (v + XW'(1 << (FRAC_XY - 1))) >>> FRAC_XY;
`ifdef POLAR_TO_CART_SAT_EN
    if (w_rnd > XW'(127))       return 8'sh7f;
    else if (w_rnd < XW'(-128)) return 8'sh80;
    else                        return 8'(w_rnd);
`else
    return 8'(w_rnd);
`endif
  endfunction

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nx = S_PREP;
      S_PREP:                 w_state_nx = S_ITER;
      S_ITER:  if (w_last)    w_state_nx = S_DONE;
      S_DONE:  if (out_ready) w_state_nx = S_IDLE;
      default:                w_state_nx = S_IDLE;
    endcase
  end

  // r_live keeps in_ready low while reset is held and for the release edge.
  always_comb begin
    in_ready  = (r_state == S_IDLE) && r_live;
    out_valid = (r_state == S_DONE);
    x         = r_x;
    y         = r_y;
    out_err   = r_oerr;
  end

  // Quadrant pre-rotation folds |theta| > 90 into the CORDIC convergence range.
  always_comb begin
    w_bad   = (r_theta > 9'sd180) || (r_theta < -9'sd180);
    w_xinit = signed'(XW'(r_r) * XW'(K_INV));
    w_zinit = ZW'(r_theta) <<< FRAC_Z;
    if (!w_bad && (r_theta > 9'sd90)) begin
      w_xinit = -w_xinit;
      w_zinit = w_zinit - ZW'(HALF_TURN);
    end else if (!w_bad && (r_theta < -9'sd90)) begin
      w_xinit = -w_xinit;
      w_zinit = w_zinit + ZW'(HALF_TURN);
    end
  end

  polar_to_cart_step u_step (
    .i_x    (r_xacc),
    .i_y    (r_yacc),
    .i_z    (r_zacc),
    .i_idx  (r_cnt),
    .i_atan (ATAN_TAB[r_cnt]),
    .o_x    (w_xn),
    .o_y    (w_yn),
    .o_z    (w_zn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live  <= 1'b0;
      r_cnt   <= '0;
      r_r     <= '0;
      r_theta <= '0;
      r_xacc  <= '0;
      r_yacc  <= '0;
      r_zacc  <= '0;
      r_err   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_oerr  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_r     <= r;
            r_theta <= theta;
          end
        end
        S_PREP: begin
          r_xacc <= w_xinit;
          r_yacc <= '0;
          r_zacc <= w_zinit;
          r_err  <= w_bad;
          r_cnt  <= '0;
        end
        S_ITER: begin
          r_xacc <= w_xn;
          r_yacc <= w_yn;
          r_zacc <= w_zn;
          r_cnt  <= r_cnt + IW'(1);
          // Results are latched from the final step output as DONE is entered.
          if (w_last) begin
            r_x    <= r_err ? '0 : fit8(w_xn);
            r_y    <= r_err ? '0 : fit8(w_yn);
            r_oerr <= r_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_polar_to_cart.sv
// Scoreboard bench for polar_to_cart: driver pushes hand-computed results,
// a negedge monitor pops and compares on every output transfer.
module tb_polar_to_cart;

  localparam int ITER = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic        [7:0] r = '0;
  logic signed [8:0] theta = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [7:0] x;
  logic signed [7:0] y;
  logic              out_err;

  typedef struct {
    int    ex;
    int    ey;
    int    eerr;
    int    tol;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   acc_log[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_xfer = 0;
  int   n_acc = 0;
  bit   prev_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  polar_to_cart #(.ITER(ITER)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r         (r),
    .theta     (theta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .y         (y),
    .out_err   (out_err)
  );

  task automatic check(input string nm, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    n_cmp++;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
        n_acc++;
      end
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) check("latency_orphan", 1, 0, 0);
        else check("latency", cyc + 1 - acc_q.pop_front(), ITER + 2, 0);
      end
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        n_xfer++;
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0, 0);
        end else begin
          m_e = sb.pop_front();
          check({m_e.nm, ".x"}, int'(x), m_e.ex, m_e.tol);
          check({m_e.nm, ".y"}, int'(y), m_e.ey, m_e.tol);
          check({m_e.nm, ".err"}, int'(out_err), m_e.eerr, 0);
        end
      end
    end
  end

  task automatic send(input int rr, input int th, input int ex, input int ey,
                      input int eerr, input int tol, input string nm);
    exp_t e;
    bit   done;
    done = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    r        = 8'(rr);
    theta    = 9'(th);
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.ex = ex; e.ey = ey; e.eerr = eerr; e.tol = tol; e.nm = nm;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check({nm, ".accept_timeout"}, 0, 1, 0);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({nm, ".drain_timeout"}, sb.size(), 0, 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_x, base_acc, n;
    logic signed [7:0] sx, sy;
    logic se;

    #1 rst_n = 1'b0;
    #1;
    check("rst.in_ready", int'(in_ready), 0, 0);
    check("rst.out_valid", int'(out_valid), 0, 0);
    check("rst.x", int'(x), 0, 0);
    check("rst.y", int'(y), 0, 0);
    check("rst.out_err", int'(out_err), 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    check("rel.in_ready_low", int'(in_ready), 0, 0);
    @(negedge clk);
    check("rel.in_ready_high", int'(in_ready), 1, 0);

    send(100,    0,  100,    0, 0, 1, "r100_t0");
    send(100,   90,    0,  100, 0, 1, "r100_t90");
    send(100,  180, -100,    0, 0, 1, "r100_t180");
    send(100,  -90,    0, -100, 0, 1, "r100_tm90");
    send(100,  -45,   71,  -71, 0, 1, "r100_tm45");
    send(127,  135,  -90,   90, 0, 1, "r127_t135");
    send(0,     37,    0,    0, 0, 0, "r0_t37");
`ifdef POLAR_TO_CART_SAT_EN
    send(200,    0,  127,    0, 0, 1, "r200_sat");
`else
    send(200,    0,  -56,    0, 0, 1, "r200_wrap");
`endif
    send(100,  200,    0,    0, 1, 0, "bad_t200");
    send(50,     0,   50,    0, 0, 1, "err_clear");
    drain("directed");
    if (acc_log.size() >= 2) check("throughput", acc_log[1] - acc_log[0], ITER + 3, 0);
    else check("throughput.accepts", acc_log.size(), 2, 0);

    // Consumer stall: result held, new requests ignored, single transfer on release.
    #1 out_ready = 1'b0;
    base_x = n_xfer;
    send(100, 60, 50, 87, 0, 1, "stall");
    base_acc = n_acc;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall.valid_seen", int'(out_valid), 1, 0);
    sx = x; sy = y; se = out_err;
    @(posedge clk); #1;
    in_valid = 1'b1; r = 8'd5; theta = 9'sd10;
    repeat (5) begin
      @(negedge clk);
      check("stall.x_stable", int'(x), int'(sx), 0);
      check("stall.y_stable", int'(y), int'(sy), 0);
      check("stall.err_stable", int'(out_err), int'(se), 0);
      check("stall.in_ready", int'(in_ready), 0, 0);
      check("stall.out_valid", int'(out_valid), 1, 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("stall.one_xfer", n_xfer - base_x, 1, 0);
    check("stall.no_accept", n_acc - base_acc, 0, 0);
    check("stall.sb_empty", sb.size(), 0, 0);

    // Reset in the middle of ITER aborts the request without output.
    send(100, 30, 87, 50, 0, 1, "aborted");
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    sb.delete();
    acc_q.delete();
    #1;
    check("midrst.in_ready", int'(in_ready), 0, 0);
    check("midrst.out_valid", int'(out_valid), 0, 0);
    check("midrst.x", int'(x), 0, 0);
    check("midrst.y", int'(y), 0, 0);
    check("midrst.out_err", int'(out_err), 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst.in_ready_back", int'(in_ready), 1, 0);
    send(100, 30, 87, 50, 0, 1, "post_reset");
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
